reg_wb_scheduler: RTL and testbench
===================================

Name: reg_wb_scheduler

Overview:
- Sequences the single write port of the 32x32 RISC-V register file between two writeback sources.
  - ALU: single-cycle, never backpressured.
  - MEM: long-latency load/mul-div, backpressured by ready.
- Holds colliding MEM results in a small FIFO.
- Keeps a pending-write scoreboard that stalls decode on RAW/WAW hazards against outstanding long-latency ops.
- Sits between execute/memory writeback and the register file's RegWEn/AddrD/DataD inputs.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural registers; register 0 is hardwired zero.
- BUF_DEPTH, 2, MEM result FIFO entries (power of two, at least 1).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- IssueValid  in  1  decode presents an instruction this cycle.
- IssueRs1  in  5  source register 1.
- IssueRs2  in  5  source register 2.
- IssueRd  in  5  destination register.
- IssueLong  in  1  instruction completes through the MEM path.
- IssueStall  out  1  decode must hold; issue is not accepted.
- AluWbValid  in  1  ALU result valid.
- AluWbRd  in  5  ALU destination.
- AluWbData  in  XLEN  ALU result.
- MemWbValid  in  1  MEM result valid.
- MemWbRd  in  5  MEM destination.
- MemWbData  in  XLEN  MEM result.
- MemWbReady  out  1  MEM result accepted when Valid and Ready are both high.
- RegWEn  out  1  register file write enable.
- AddrD  out  5  register file write address.
- DataD  out  XLEN  register file write data.
- Pending  out  NREG  scoreboard bitmap (debug/verification).

Behaviour:
- Reset (RST_N low, asynchronous): FIFO emptied (count 0), Pending=0. Outputs while in reset: RegWEn=0, IssueStall=0, MemWbReady=1, AddrD=0, DataD=0.
- Reset mid-operation discards buffered MEM results and clears all pending bits; no write is issued.
- Write-port selection is combinational, so the register file writes on the same edge (0-cycle latency). Priority order:
  1. ALU, when AluWbValid and AluWbRd!=0.
  2. FIFO head, when count>0.
  3. Direct MEM bypass, when count==0 and MemWbValid and MemWbRd!=0.
  4. Otherwise RegWEn=0.
- AluWbValid with AluWbRd==0: consumed, RegWEn=0; the MEM/FIFO source may use the port that cycle.
- MemWbReady = (count < BUF_DEPTH).
  - An accepted MEM result not taken by direct bypass is pushed to the FIFO.
  - An accepted MEM result with rd==0 is discarded; no push, no write.
- FIFO push and pop in the same cycle: count unchanged, order preserved (strict FIFO).
- When count==BUF_DEPTH: MemWbReady=0. A pop that cycle frees a slot for the next cycle only; Ready does not depend on the same-cycle pop.
- Scoreboard set: Pending[IssueRd] is set when IssueValid & !IssueStall & IssueLong & IssueRd!=0.
- Scoreboard clear: Pending[rd] is cleared when a MEM-sourced write (FIFO head or bypass) to rd commits.
- Set and clear of the same rd in one cycle: set wins.
- Pending[0] is constant 0.
- IssueStall = IssueValid & (Pending[IssueRs1] | Pending[IssueRs2] | Pending[IssueRd]).
  - Covers RAW on both sources and WAW on rd.
  - Purely combinational from current Pending; no forwarding from a same-cycle clear.
- Invariant (checked by assertion): the ALU never writes an rd whose Pending bit is set.
- Invariant (checked by assertion): a MEM writeback always targets a register with its Pending bit set.

Decomposition:
- Shared package rv_pkg: XLEN, NREG, REG_ADDR_W=5, and a wb_entry_t struct {rd, data}.
- One sub-module: wb_fifo (parameterised depth, push/pop/count, simultaneous push+pop).
- Arbiter and scoreboard stay in the top module.

Test Plan:
- Reset, then ALU only: AluWbValid=1, AluWbRd=5, AluWbData=0xDEADBEEF -> same cycle RegWEn=1, AddrD=5, DataD=0xDEADBEEF. Pending stays 0.
- Long-op scoreboard: issue IssueLong with rd=7 -> Pending[7]=1. Next issue with rs1=7 -> IssueStall=1, holding until a MEM write to x7 (0x1234) commits. The stall releases the following cycle.
- Collision: ALU (rd=3) and MEM (rd=4, 0xAA) valid in the same cycle -> x3 written first, MEM pushed (count=1). Next idle cycle x4=0xAA is written from the FIFO.
- Backpressure: three ALU writes back-to-back while MEM offers rd=8/9/10 -> first two buffered, MemWbReady=0 on the third. Writes then drain in order 8, 9, 10.
- x0 handling: AluWbRd=0 together with MEM bypass rd=6 -> RegWEn writes x6. Issue IssueLong rd=0 -> Pending unchanged. MEM rd=0 is accepted and never written.
- Async reset with count=2 and Pending[12]=1: RST_N low mid-cycle -> immediately RegWEn=0, MemWbReady=1, Pending=0. After release, no stale writes appear.

Source files
------------

// File: rtl/reg_wb_scheduler_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package reg_wb_scheduler_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot = NREG'(1) << r;
  endfunction
endpackage

// File: rtl/reg_wb_scheduler_if.sv
// Decode/writeback/register-file signal bundle; master drives issue and results, slave is the scheduler.
interface reg_wb_scheduler_if;
  import reg_wb_scheduler_pkg::*;

  logic                  IssueValid;
  logic [REG_ADDR_W-1:0] IssueRs1;
  logic [REG_ADDR_W-1:0] IssueRs2;
  logic [REG_ADDR_W-1:0] IssueRd;
  logic                  IssueLong;
  logic                  IssueStall;
  logic                  AluWbValid;
  logic [REG_ADDR_W-1:0] AluWbRd;
  logic [XLEN-1:0]       AluWbData;
  logic                  MemWbValid;
  logic [REG_ADDR_W-1:0] MemWbRd;
  logic [XLEN-1:0]       MemWbData;
  logic                  MemWbReady;
  logic                  RegWEn;
  logic [REG_ADDR_W-1:0] AddrD;
  logic [XLEN-1:0]       DataD;
  logic [NREG-1:0]       Pending;

  modport master (
    output IssueValid, IssueRs1, IssueRs2, IssueRd, IssueLong,
    output AluWbValid, AluWbRd, AluWbData, MemWbValid, MemWbRd, MemWbData,
    input  IssueStall, MemWbReady, RegWEn, AddrD, DataD, Pending
  );

  modport slave (
    input  IssueValid, IssueRs1, IssueRs2, IssueRd, IssueLong,
    input  AluWbValid, AluWbRd, AluWbData, MemWbValid, MemWbRd, MemWbData,
    output IssueStall, MemWbReady, RegWEn, AddrD, DataD, Pending
  );
endinterface

// File: rtl/reg_wb_scheduler_chk.sv
// Protocol invariants between the scoreboard and the two writeback sources.
module reg_wb_scheduler_chk
  import reg_wb_scheduler_pkg::*;
(
  input logic                  clk_i,
  input logic                  rst_ni,
  input logic                  alu_wr_i,
  input logic [REG_ADDR_W-1:0] alu_rd_i,
  input logic                  mem_commit_i,
  input logic [REG_ADDR_W-1:0] mem_rd_i,
  input logic [NREG-1:0]       pending_i
);
  a_alu_not_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    alu_wr_i |-> !pending_i[alu_rd_i]);

  a_mem_is_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_commit_i |-> pending_i[mem_rd_i]);
endmodule

// File: rtl/reg_wb_scheduler_fifo.sv
// Strict-order FIFO holding MEM results that lost the write port; push and pop may coincide.
module wb_fifo
  import reg_wb_scheduler_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  wb_entry_t        push_data_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o
);
  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy; the caller never pushes while full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/reg_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU and MEM writeback
// and tracks outstanding long-latency destinations to stall decode on hazards.
module reg_wb_scheduler
  import reg_wb_scheduler_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  reg_wb_scheduler_if.slave  bus
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                  alu_wr_s, pop_s, push_s, bypass_s, ready_s, stall_s, issue_set_s;
  logic                  we_s, mem_commit_s;
  logic [REG_ADDR_W-1:0] addr_s;
  logic [XLEN-1:0]       data_s;
  logic [CNT_W-1:0]      count_s;
  wb_entry_t             head_s, push_entry_s;
  logic [NREG-1:0]       pending_q, pending_d;

  wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  // Source selection: ALU, then buffered MEM, then direct MEM bypass.
  always_comb begin
    alu_wr_s     = bus.AluWbValid && (bus.AluWbRd != '0);
    ready_s      = (count_s < CNT_W'(BUF_DEPTH));
    pop_s        = !alu_wr_s && (count_s != '0);
    bypass_s     = !alu_wr_s && (count_s == '0) && bus.MemWbValid && (bus.MemWbRd != '0);
    push_s       = bus.MemWbValid && ready_s && (bus.MemWbRd != '0) && !bypass_s;
    push_entry_s = '{rd: bus.MemWbRd, data: bus.MemWbData};
    we_s         = 1'b0;
    mem_commit_s = 1'b0;
    addr_s       = '0;
    data_s       = '0;
    if (alu_wr_s) begin
      we_s   = 1'b1;
      addr_s = bus.AluWbRd;
      data_s = bus.AluWbData;
    end else if (pop_s) begin
      we_s         = 1'b1;
      mem_commit_s = 1'b1;
      addr_s       = head_s.rd;
      data_s       = head_s.data;
    end else if (bypass_s) begin
      we_s         = 1'b1;
      mem_commit_s = 1'b1;
      addr_s       = bus.MemWbRd;
      data_s       = bus.MemWbData;
    end else begin
      we_s = 1'b0;
    end
  end

  // Hazard stall and scoreboard next state; a same-cycle set overrides the clear.
  always_comb begin
    stall_s     = bus.IssueValid &&
                  (pending_q[bus.IssueRs1] || pending_q[bus.IssueRs2] || pending_q[bus.IssueRd]);
    issue_set_s = bus.IssueValid && !stall_s && bus.IssueLong && (bus.IssueRd != '0);
    pending_d   = pending_q;
    if (mem_commit_s) begin
      pending_d = pending_d & ~reg_onehot(addr_s);
    end else begin
      pending_d = pending_d;
    end
    if (issue_set_s) begin
      pending_d = pending_d | reg_onehot(bus.IssueRd);
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  // Pending-write scoreboard.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // The write port must be quiet while reset is asserted, even with sources valid.
  assign bus.RegWEn     = RST_N & we_s;
  assign bus.AddrD      = RST_N ? addr_s : '0;
  assign bus.DataD      = RST_N ? data_s : '0;
  assign bus.MemWbReady = ready_s;
  assign bus.IssueStall = stall_s;
  assign bus.Pending    = pending_q;

  reg_wb_scheduler_chk u_chk (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .alu_wr_i     (alu_wr_s),
    .alu_rd_i     (bus.AluWbRd),
    .mem_commit_i (mem_commit_s),
    .mem_rd_i     (addr_s),
    .pending_i    (pending_q)
  );
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Self-checking bench: per-cycle vector table plus a write-order scoreboard and an async-reset sequence.
module tb_reg_wb_scheduler;
  import reg_wb_scheduler_pkg::*;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  reg_wb_scheduler_if bus ();

  reg_wb_scheduler #(.BUF_DEPTH(2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;  logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic il;
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
    logic        we;  logic [4:0] addr; logic [31:0] data;
    logic        rdy; logic stall; logic [31:0] pend;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [36:0] sb[$];
  logic [36:0] sb_exp;
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic il,
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
    input logic we, input logic [4:0] addr, input logic [31:0] data,
    input logic rdy, input logic stall, input logic [31:0] pend);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.il = il;
    v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.we = we; v.addr = addr; v.data = data;
    v.rdy = rdy; v.stall = stall; v.pend = pend;
    return v;
  endfunction

  task automatic drive_idle();
    bus.IssueValid = 1'b0; bus.IssueRs1 = 5'd0; bus.IssueRs2 = 5'd0; bus.IssueRd = 5'd0;
    bus.IssueLong  = 1'b0;
    bus.AluWbValid = 1'b0; bus.AluWbRd = 5'd0; bus.AluWbData = 32'd0;
    bus.MemWbValid = 1'b0; bus.MemWbRd = 5'd0; bus.MemWbData = 32'd0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(posedge CLK);
    #1;
    bus.IssueValid = v.iv; bus.IssueRs1 = v.rs1; bus.IssueRs2 = v.rs2; bus.IssueRd = v.rd;
    bus.IssueLong  = v.il;
    bus.AluWbValid = v.av; bus.AluWbRd = v.ard; bus.AluWbData = v.adat;
    bus.MemWbValid = v.mv; bus.MemWbRd = v.mrd; bus.MemWbData = v.mdat;
    if (v.we) sb.push_back({v.addr, v.data});
    #1;
    check({tag, "_we"}, {31'd0, bus.RegWEn}, {31'd0, v.we});
    if (v.we) begin
      check({tag, "_addr"}, {27'd0, bus.AddrD}, {27'd0, v.addr});
      check({tag, "_data"}, bus.DataD, v.data);
    end
    check({tag, "_ready"}, {31'd0, bus.MemWbReady}, {31'd0, v.rdy});
    check({tag, "_stall"}, {31'd0, bus.IssueStall}, {31'd0, v.stall});
    check({tag, "_pending"}, bus.Pending, v.pend);
  endtask

  // Every observed register-file write must match the next expected write, in order.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && bus.RegWEn === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: write x%0d=0x%08h with nothing expected", bus.AddrD, bus.DataD);
      end else begin
        sb_exp = sb.pop_front();
        check("sb_addr", {27'd0, bus.AddrD}, {27'd0, sb_exp[36:32]});
        check("sb_data", bus.DataD, sb_exp[31:0]);
      end
    end
  end

  initial begin
    //        iv   rs1   rs2   rd    il    av   ard   adat          mv   mrd   mdat          we   addr  data          rdy  stall pend
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,5'd5, 32'hDEADBEEF, 1'b0,5'd0, 32'h0,        1'b1,5'd5, 32'hDEADBEEF, 1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd7, 1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,5'd7, 5'd0, 5'd1, 1'b0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b1,32'h80));
    vecs.push_back(mk(1'b1,5'd7, 5'd0, 5'd1, 1'b0, 1'b0,5'd0, 32'h0,        1'b1,5'd7, 32'h1234,     1'b1,5'd7, 32'h1234,     1'b1,1'b1,32'h80));
    vecs.push_back(mk(1'b1,5'd7, 5'd0, 5'd1, 1'b0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd4, 1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,5'd3, 32'h33,       1'b1,5'd4, 32'hAA,       1'b1,5'd3, 32'h33,       1'b1,1'b0,32'h10));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd4, 32'hAA,       1'b1,1'b0,32'h10));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd8, 1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd9, 1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h100));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd10,1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h300));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,5'd1, 32'h11,       1'b1,5'd8, 32'h80,       1'b1,5'd1, 32'h11,       1'b1,1'b0,32'h700));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,5'd2, 32'h22,       1'b1,5'd9, 32'h90,       1'b1,5'd2, 32'h22,       1'b1,1'b0,32'h700));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,5'd3, 32'h333,      1'b1,5'd10,32'h100,      1'b1,5'd3, 32'h333,      1'b0,1'b0,32'h700));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b0,5'd0, 32'h0,        1'b1,5'd10,32'h100,      1'b1,5'd8, 32'h80,       1'b0,1'b0,32'h700));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b0,5'd0, 32'h0,        1'b1,5'd10,32'h100,      1'b1,5'd9, 32'h90,       1'b1,1'b0,32'h600));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd10,32'h100,      1'b1,1'b0,32'h400));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd6, 1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,5'd0, 32'hFF,       1'b1,5'd6, 32'h66,       1'b1,5'd6, 32'h66,       1'b1,1'b0,32'h40));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd0, 1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b0,5'd0, 32'h0,        1'b1,5'd0, 32'h55,       1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd11,1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd11,1'b0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b1,32'h800));
    vecs.push_back(mk(1'b1,5'd0, 5'd11,5'd1, 1'b0, 1'b0,5'd0, 32'h0,        1'b1,5'd11,32'hB1,       1'b1,5'd11,32'hB1,       1'b1,1'b1,32'h800));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    // Fill the FIFO with x12/x13 outstanding, ready for the mid-operation reset.
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd12,1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 5'd13,1'b1, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,32'h1000));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,5'd1, 32'hA1,       1'b1,5'd12,32'hC12,      1'b1,5'd1, 32'hA1,       1'b1,1'b0,32'h3000));
    vecs.push_back(mk(1'b0,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,5'd2, 32'hA2,       1'b1,5'd13,32'hC13,      1'b1,5'd2, 32'hA2,       1'b1,1'b0,32'h3000));

    // Reset held with an ALU result offered: the write port must stay quiet.
    drive_idle();
    bus.AluWbValid = 1'b1; bus.AluWbRd = 5'd5; bus.AluWbData = 32'hDEADBEEF;
    #3;
    check("rst_we",      {31'd0, bus.RegWEn},     32'd0);
    check("rst_addr",    {27'd0, bus.AddrD},      32'd0);
    check("rst_data",    bus.DataD,               32'd0);
    check("rst_ready",   {31'd0, bus.MemWbReady}, 32'd1);
    check("rst_stall",   {31'd0, bus.IssueStall}, 32'd0);
    check("rst_pending", bus.Pending,             32'd0);
    @(posedge CLK);
    #3;
    drive_idle();
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // FIFO holds two results and x12/x13 are pending; reset lands mid-cycle.
    @(posedge CLK);
    #1;
    drive_idle();
    bus.IssueValid = 1'b1; bus.IssueRs1 = 5'd12; bus.IssueRd = 5'd1;
    #1;
    check("pre_rst_ready", {31'd0, bus.MemWbReady}, 32'd0);
    check("pre_rst_stall", {31'd0, bus.IssueStall}, 32'd1);
    RST_N = 1'b0;
    #1;
    check("async_rst_we",      {31'd0, bus.RegWEn},     32'd0);
    check("async_rst_ready",   {31'd0, bus.MemWbReady}, 32'd1);
    check("async_rst_pending", bus.Pending,             32'd0);
    check("async_rst_stall",   {31'd0, bus.IssueStall}, 32'd0);
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #2;
      check($sformatf("post_rst%0d_we", i),    {31'd0, bus.RegWEn},     32'd0);
      check($sformatf("post_rst%0d_ready", i), {31'd0, bus.MemWbReady}, 32'd1);
      check($sformatf("post_rst%0d_stall", i), {31'd0, bus.IssueStall}, 32'd0);
    end
    @(negedge CLK);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
